// File: rtl/audio_stream_player.sv
// Byte-stream to multi-channel PCM player: frame assembler, frame FIFO,
// fixed-rate playback with prebuffer/underrun handling and hysteretic cts.
module audio_stream_player #(
   parameter int SAMPLE_BITS    = 16,
   parameter int CHANNELS       = 2,
   parameter int DEPTH          = 1024,
   parameter int CLK_FREQ       = 12_000_000,
   parameter int SAMPLE_RATE    = 22_050,
   parameter int LOW_MARK       = DEPTH / 4,
   parameter int HIGH_MARK      = 3 * DEPTH / 4,
   parameter int TIMEOUT_CYCLES = 4 * (CLK_FREQ / SAMPLE_RATE),
   parameter int SIGNED         = 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [7:0]                      rx_byte,
   input  logic                            rx_valid,
   output logic [CHANNELS*SAMPLE_BITS-1:0] sample_out,
   output logic                            sample_ce,
   output logic                            mute,
   output logic                            cts,
   output logic [$clog2(DEPTH):0]          fill,
   output logic [15:0]                     underrun_count,
   output logic [15:0]                     overrun_count
);

   localparam int SAMPLE_BYTES = (SAMPLE_BITS + 7) / 8;
   localparam int FRAME_BYTES  = CHANNELS * SAMPLE_BYTES;
   localparam int FRAME_W      = CHANNELS * SAMPLE_BITS;
   localparam int AW           = $clog2(DEPTH);
   localparam int DIV          = CLK_FREQ / SAMPLE_RATE;
   localparam int TW           = $clog2(DIV);
   localparam int GW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IW           = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

   localparam logic [AW:0]         FULL_LVL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]         LOW_LVL     = (AW+1)'(LOW_MARK);
   localparam logic [AW:0]         HIGH_LVL    = (AW+1)'(HIGH_MARK);
   localparam logic [TW-1:0]       TICK_RELOAD = TW'(DIV - 1);
   localparam logic [GW-1:0]       GAP_MAX     = GW'(TIMEOUT_CYCLES);
   localparam logic [IW-1:0]       LAST_IDX    = IW'(FRAME_BYTES - 1);
   localparam logic [31:0]         MID32       = 32'd1 << (SAMPLE_BITS - 1);
   localparam logic [SAMPLE_BITS-1:0] MID_S    = MID32[SAMPLE_BITS-1:0];
   localparam logic [FRAME_W-1:0]  MID_FRAME   = {CHANNELS{MID_S}};
   localparam logic [FRAME_W-1:0]  SIGN_MASK   = (SIGNED != 0) ? MID_FRAME : '0;

   typedef enum logic {A_IDLE, A_COLLECT} asm_t;
   typedef enum logic {P_PRIME, P_PLAY}   play_t;

   asm_t               asm_q, asm_d;
   play_t              play_q, play_d;
   logic [7:0]         buf_q [FRAME_BYTES];
   logic [7:0]         buf_d [FRAME_BYTES];
   logic [IW-1:0]      idx_q, idx_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic               pend_vld_q, pend_vld_d;
   logic [FRAME_W-1:0] pend_q, pend_d;

   logic [FRAME_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]        cnt_q, cnt_d;
   logic               full, push, drop, pop;

   logic [TW-1:0]      tick_cnt_q;
   logic               tick;
   logic [FRAME_W-1:0] out_q, out_d, load;
   logic               ce_q, mute_q, mute_d, cts_q, cts_d;
   logic [15:0]        und_q, und_d, ovr_q, ovr_d;

   logic [FRAME_BYTES*8-1:0] flat_c;
   logic [FRAME_W-1:0]       frame_c;

   // The frame is built from the buffer with the incoming byte already
   // inserted, so the last byte and the commit happen in the same edge.
   always_comb begin
      asm_d      = asm_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      pend_vld_d = 1'b0;
      pend_d     = pend_q;
      gap_d      = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
      flat_c     = '0;
      frame_c    = '0;
      if (rx_valid) begin
         gap_d        = '0;
         buf_d[idx_q] = rx_byte;
      end
      for (int unsigned b = 0; b < FRAME_BYTES; b++)
         flat_c[b*8 +: 8] = buf_d[b];
      for (int unsigned c = 0; c < CHANNELS; c++)
         frame_c[c*SAMPLE_BITS +: SAMPLE_BITS] = flat_c[c*SAMPLE_BYTES*8 +: SAMPLE_BITS];
      if (rx_valid) begin
         if (idx_q == LAST_IDX) begin
            pend_vld_d = 1'b1;
            pend_d     = frame_c;
            idx_d      = '0;
            asm_d      = A_IDLE;
         end else begin
            idx_d = idx_q + 1'b1;
            asm_d = A_COLLECT;
         end
      end else if (asm_q == A_COLLECT && gap_d == GAP_MAX) begin
         asm_d = A_IDLE;
         idx_d = '0;
      end
   end

   assign full = (cnt_q == FULL_LVL);
   assign push = pend_vld_q & ~full;
   assign drop = pend_vld_q & full;
   assign tick = (tick_cnt_q == '0);
   assign load = mem[rd_ptr_q] ^ SIGN_MASK;

   always_comb begin
      play_d = play_q;
      pop    = 1'b0;
      out_d  = out_q;
      mute_d = mute_q;
      und_d  = und_q;
      ovr_d  = ovr_q;
      cts_d  = cts_q;
      if (drop && ovr_q != 16'hFFFF)
         ovr_d = ovr_q + 16'd1;
      if (tick) begin
         case (play_q)
            P_PRIME: begin
               if (cnt_q >= LOW_LVL) begin
                  pop    = 1'b1;
                  play_d = P_PLAY;
                  out_d  = load;
                  mute_d = 1'b0;
               end else begin
                  out_d  = MID_FRAME;
                  mute_d = 1'b1;
               end
            end
            P_PLAY: begin
               if (cnt_q != '0) begin
                  pop   = 1'b1;
                  out_d = load;
               end else begin
                  if (und_q != 16'hFFFF)
                     und_d = und_q + 16'd1;
                  play_d = P_PRIME;
                  out_d  = MID_FRAME;
                  mute_d = 1'b1;
               end
            end
            default: play_d = P_PRIME;
         endcase
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (cnt_q >= HIGH_LVL)
         cts_d = 1'b0;
      else if (cnt_q <= LOW_LVL)
         cts_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset_n && push)
         mem[wr_ptr_q] <= pend_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         asm_q      <= A_IDLE;
         play_q     <= P_PRIME;
         buf_q      <= '{default: '0};
         idx_q      <= '0;
         gap_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         tick_cnt_q <= TICK_RELOAD;
         out_q      <= MID_FRAME;
         ce_q       <= 1'b0;
         mute_q     <= 1'b1;
         cts_q      <= 1'b1;
         und_q      <= '0;
         ovr_q      <= '0;
      end else begin
         asm_q      <= asm_d;
         play_q     <= play_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         pend_vld_q <= pend_vld_d;
         pend_q     <= pend_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q      <= cnt_d;
         tick_cnt_q <= tick ? TICK_RELOAD : tick_cnt_q - 1'b1;
         out_q      <= out_d;
         ce_q       <= tick;
         mute_q     <= mute_d;
         cts_q      <= cts_d;
         und_q      <= und_d;
         ovr_q      <= ovr_d;
      end
   end

   assign sample_out     = out_q;
   assign sample_ce      = ce_q;
   assign mute           = mute_q;
   assign cts            = cts_q;
   assign fill           = cnt_q;
   assign underrun_count = und_q;
   assign overrun_count  = ovr_q;

endmodule

// File: tb/tb_audio_stream_player.sv
// Bench for audio_stream_player: directed scenarios with fixed expectations
// plus randomized byte traffic checked every cycle against a queue model.
module tb_audio_stream_player;

   localparam int DIV   = 10;
   localparam int LOW   = 2;
   localparam int HIGH  = 6;
   localparam int DEPTH = 8;
   localparam int TMO   = 20;
   localparam logic [31:0] MID = 32'h8000_8000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic [31:0] sample_out;
   logic        sample_ce, mute, cts;
   logic [3:0]  fill;
   logic [15:0] underrun_count, overrun_count;

   always #5 clk = ~clk;

   audio_stream_player #(
      .SAMPLE_BITS(16), .CHANNELS(2), .DEPTH(DEPTH), .CLK_FREQ(100),
      .SAMPLE_RATE(10), .LOW_MARK(LOW), .HIGH_MARK(HIGH),
      .TIMEOUT_CYCLES(TMO), .SIGNED(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .sample_out(sample_out), .sample_ce(sample_ce), .mute(mute), .cts(cts),
      .fill(fill), .underrun_count(underrun_count), .overrun_count(overrun_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: frames as a queue, partial frame as a byte list.
   logic [31:0] m_fifo[$];
   logic [7:0]  m_bytes[$];
   bit          m_pend_v;
   logic [31:0] m_pend;
   int          m_gap, m_cyc, m_under, m_over;
   bit          m_playing, m_mute, m_ce, m_cts;
   logic [31:0] m_out;

   function automatic logic [31:0] to_offset(input logic [31:0] raw);
      logic [31:0] o;
      for (int c = 0; c < 2; c++)
         o[c*16 +: 16] = raw[c*16 +: 16] + 16'd32768;
      return o;
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_bytes.delete();
      m_pend_v  = 0;
      m_pend    = '0;
      m_gap     = 0;
      m_cyc     = 0;
      m_under   = 0;
      m_over    = 0;
      m_playing = 0;
      m_mute    = 1;
      m_ce      = 0;
      m_cts     = 1;
      m_out     = MID;
   endtask

   task automatic model_edge(input bit rst_n, input bit v, input logic [7:0] b);
      int  old_cnt;
      bit  tick;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_cyc++;
      tick    = (m_cyc % DIV) == 0;
      old_cnt = m_fifo.size();
      if (old_cnt >= HIGH) m_cts = 0;
      else if (old_cnt <= LOW) m_cts = 1;
      m_ce = tick;
      if (tick) begin
         if (!m_playing && old_cnt >= LOW) begin
            m_out = to_offset(m_fifo.pop_front());
            m_playing = 1;
            m_mute = 0;
         end else if (m_playing && old_cnt > 0) begin
            m_out = to_offset(m_fifo.pop_front());
         end else begin
            if (m_playing && m_under < 65535) m_under++;
            m_playing = 0;
            m_out = MID;
            m_mute = 1;
         end
      end
      if (m_pend_v) begin
         if (old_cnt < DEPTH) m_fifo.push_back(m_pend);
         else if (m_over < 65535) m_over++;
      end
      m_pend_v = 0;
      if (v) begin
         m_gap = 0;
         m_bytes.push_back(b);
         if (m_bytes.size() == 4) begin
            m_pend   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_pend_v = 1;
            m_bytes.delete();
         end
      end else begin
         m_gap++;
         if (m_bytes.size() != 0 && m_gap >= TMO) m_bytes.delete();
      end
   endtask

   task automatic compare_all();
      check("sample_out", sample_out, m_out);
      check("sample_ce", sample_ce, m_ce);
      check("mute", mute, m_mute);
      check("cts", cts, m_cts);
      check("fill", fill, m_fifo.size());
      check("underrun", underrun_count, m_under);
      check("overrun", overrun_count, m_over);
   endtask

   task automatic step(input bit rst_n, input bit v, input logic [7:0] b);
      reset_n  = rst_n;
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk);
      model_edge(rst_n, v, b);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 8'h00);
   endtask

   task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
      step(1, 1, b0);
      step(1, 1, b1);
      step(1, 1, b2);
      step(1, 1, b3);
   endtask

   task automatic wait_tick();
      bit seen = 0;
      for (int i = 0; i < 2*DIV && !seen; i++) begin
         step(1, 0, 8'h00);
         seen = m_ce;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit         seen;
      int         prev;
      int         pct;
      logic [7:0] rb;
      model_reset();
      @(negedge clk);

      // Reset state
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
      check("rst_out", sample_out, MID);
      check("rst_ce", sample_ce, 0);
      check("rst_mute", mute, 1);
      check("rst_cts", cts, 1);
      check("rst_fill", fill, 0);
      check("rst_under", underrun_count, 0);
      check("rst_over", overrun_count, 0);

      // Prebuffer, format conversion, underrun and restart
      send_frame(8'h34, 8'h12, 8'h78, 8'h56);
      send_frame(8'h00, 8'h80, 8'hFF, 8'h7F);
      idle(1);
      check("prebuf_fill", fill, 2);
      wait_tick();
      check("play1_out", sample_out, 32'hD678_9234);
      check("play1_mute", mute, 0);
      wait_tick();
      check("play2_out", sample_out, 32'hFFFF_0000);
      wait_tick();
      check("under_cnt", underrun_count, 1);
      check("under_mute", mute, 1);
      check("under_out", sample_out, MID);
      send_frame(8'h01, 8'h02, 8'h03, 8'h04);
      wait_tick();
      check("one_frame_mute", mute, 1);
      send_frame(8'h05, 8'h06, 8'h07, 8'h08);
      wait_tick();
      check("restart_mute", mute, 0);
      check("restart_out", sample_out, 32'h8403_8201);

      // Flow control and overrun under a continuous burst
      step(0, 0, 8'h00);
      seen = 0;
      prev = 0;
      for (int i = 0; i < 64*4 && overrun_count == 0; i++) begin
         step(1, 1, 8'($urandom_range(255)));
         if (!seen && fill == 4'd6 && prev == 5) begin
            seen = 1;
            check("cts_at_high", cts, 1);
            step(1, 1, 8'($urandom_range(255)));
            check("cts_after_high", cts, 0);
         end
         prev = fill;
      end
      check("high_seen", seen, 1);
      check("overrun_seen", overrun_count != 0, 1);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step(1, 0, 8'h00);
         if (fill == 4'd4) check("cts_hyst", cts, 0);
         if (fill == 4'd2) begin
            seen = 1;
            check("cts_at_low", cts, 0);
            step(1, 0, 8'h00);
            check("cts_after_low", cts, 1);
         end
      end
      check("low_seen", seen, 1);

      // Reset mid-frame discards partial data and counters
      step(1, 1, 8'hAA);
      step(1, 1, 8'hBB);
      step(0, 0, 8'h00);
      send_frame(8'h11, 8'h22, 8'h33, 8'h44);
      idle(1);
      check("rstmid_fill", fill, 1);
      check("rstmid_under", underrun_count, 0);
      check("rstmid_over", overrun_count, 0);
      check("rstmid_out", sample_out, MID);
      check("rstmid_mute", mute, 1);

      // Timeout: 20 idle cycles drop the partial frame
      step(0, 0, 8'h00);
      step(1, 1, 8'hE1);
      step(1, 1, 8'hE2);
      step(1, 1, 8'hE3);
      idle(20);
      send_frame(8'h11, 8'h22, 8'h33, 8'h44);
      idle(2);
      check("tmo_fill", fill, 1);
      send_frame(8'h55, 8'h66, 8'h77, 8'h88);
      wait_tick();
      check("tmo_out", sample_out, 32'hC433_A211);

      // 19 idle cycles do not time out
      step(0, 0, 8'h00);
      step(1, 1, 8'h01);
      step(1, 1, 8'h02);
      step(1, 1, 8'h03);
      idle(19);
      step(1, 1, 8'h04);
      idle(2);
      check("no_tmo_fill", fill, 1);

      // Randomized traffic
      step(0, 0, 8'h00);
      pct = 60;
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            case ($urandom_range(2))
               0: pct = 95;
               1: pct = 60;
               default: pct = 20;
            endcase
         end
         if ($urandom_range(399) == 0) begin
            step(0, 0, 8'h00);
         end else if ($urandom_range(99) < pct) begin
            rb = 8'($urandom_range(255));
            step(1, 1, rb);
         end else if ($urandom_range(149) == 0) begin
            idle($urandom_range(25, 15));
         end else begin
            step(1, 0, 8'h00);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
